// File: rtl/alu_addsub_arbiter_pkg.sv
// Shared definitions for the two-requester add/sub arbiter: FSM encoding,
// operation select codes and a grant one-hot helper.
package alu_addsub_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic SelAdd = 1'b0;
  localparam logic SelSub = 1'b1;

  function automatic logic [1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/addsub_core_6b.sv
// Combinational signed add/subtract with two's complement overflow detection.
module addsub_core_6b
  import alu_addsub_arbiter_pkg::*;
#(
  parameter int unsigned W = 6
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         of
);

  always_comb begin
    if (sel == SelSub) begin
      y  = a - b;
      of = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
    end else begin
      y  = a + b;
      of = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
    end
  end

endmodule

// File: rtl/alu_addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub core between two requesters;
// results are held until the consumer accepts them.
module alu_addsub_arbiter
  import alu_addsub_arbiter_pkg::*;
#(
  parameter int unsigned W     = 6,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic             req_sel0,
  input  logic             req_sel1,
  input  logic [W-1:0]     req_a0,
  input  logic [W-1:0]     req_b0,
  input  logic [W-1:0]     req_a1,
  input  logic [W-1:0]     req_b1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_y,
  output logic             res_of,
  output logic             res_id,
  output logic [CNT_W-1:0] of_cnt
);

  state_e           state_q;
  logic             ptr_q;
  logic             sel_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             id_q;
  logic [W-1:0]     res_y_q;
  logic             res_of_q;
  logic             res_id_q;
  logic [CNT_W-1:0] of_cnt_q;

  logic             gnt_any;
  logic             gnt_id;
  logic [W-1:0]     core_y;
  logic             core_of;

  // Contention goes to the pointer; a lone requester wins regardless of it.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    case (req_valid)
      2'b01:   begin gnt_any = 1'b1; gnt_id = 1'b0;  end
      2'b10:   begin gnt_any = 1'b1; gnt_id = 1'b1;  end
      2'b11:   begin gnt_any = 1'b1; gnt_id = ptr_q; end
      default: ;
    endcase
    req_ready = 2'b00;
    if (rst_n && (state_q == StIdle) && gnt_any) req_ready = id_to_onehot(gnt_id);
  end

  addsub_core_6b #(
    .W(W)
  ) u_core (
    .sel(sel_q),
    .a  (a_q),
    .b  (b_q),
    .y  (core_y),
    .of (core_of)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= 1'b0;
      sel_q    <= SelAdd;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      res_y_q  <= '0;
      res_of_q <= 1'b0;
      res_id_q <= 1'b0;
      of_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (gnt_any) begin
            sel_q   <= gnt_id ? req_sel1 : req_sel0;
            a_q     <= gnt_id ? req_a1 : req_a0;
            b_q     <= gnt_id ? req_b1 : req_b0;
            id_q    <= gnt_id;
            ptr_q   <= ~gnt_id;
            state_q <= StExec;
          end
        end
        StExec: begin
          res_y_q  <= core_y;
          res_of_q <= core_of;
          res_id_q <= id_q;
          if (core_of && (of_cnt_q != {CNT_W{1'b1}})) of_cnt_q <= of_cnt_q + 1'b1;
          state_q  <= StResp;
        end
        StResp: begin
          if (res_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign res_valid = (state_q == StResp);
  assign res_y     = res_y_q;
  assign res_of    = res_of_q;
  assign res_id    = res_id_q;
  assign of_cnt    = of_cnt_q;

endmodule

// File: tb/tb_alu_addsub_arbiter.sv
// Scoreboard bench: the driver predicts grants and results with plain integer
// arithmetic; a monitor compares every presented result against the queue.
module tb_alu_addsub_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready, req_ready2;
  logic       req_sel0, req_sel1;
  logic [5:0] req_a0, req_b0, req_a1, req_b1;
  logic       res_valid, res_valid2;
  logic       res_ready;
  logic [5:0] res_y, res_y2;
  logic       res_of, res_of2;
  logic       res_id, res_id2;
  logic [7:0] of_cnt;
  logic [1:0] of_cnt2;

  always #5 clk = ~clk;

  alu_addsub_arbiter #(.W(6), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel0(req_sel0), .req_sel1(req_sel1), .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1), .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_of(res_of), .res_id(res_id), .of_cnt(of_cnt)
  );

  alu_addsub_arbiter #(.W(6), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
    .req_sel0(req_sel0), .req_sel1(req_sel1), .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1), .res_valid(res_valid2), .res_ready(res_ready),
    .res_y(res_y2), .res_of(res_of2), .res_id(res_id2), .of_cnt(of_cnt2)
  );

  typedef struct {
    logic [5:0] y;
    logic       of;
    logic       id;
    int         cnt8;
    int         cnt2;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference state: stage 0 = free, 1 = computing, 2 = result presented.
  int stage = 0;
  int ptr_m = 0;
  int cnt8_m = 0;
  int cnt2_m = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_y", int'(res_y), 0);
    chk("rst_res_of", int'(res_of), 0);
    chk("rst_res_id", int'(res_id), 0);
    chk("rst_of_cnt", int'(of_cnt), 0);
    chk("rst_of_cnt2", int'(of_cnt2), 0);
  endtask

  task automatic model_reset();
    sb.delete();
    stage  = 0;
    ptr_m  = 0;
    cnt8_m = 0;
    cnt2_m = 0;
  endtask

  // One clock cycle of stimulus plus grant/valid prediction.
  task automatic cycle(input logic [1:0] v, input logic s0, input logic [5:0] a0,
                       input logic [5:0] b0, input logic s1, input logic [5:0] a1,
                       input logic [5:0] b1, input logic rdy);
    int   gid;
    int   ai, bi, r;
    logic [1:0] exp_rdy;
    exp_t e;
    @(negedge clk);
    req_valid = v; req_sel0 = s0; req_a0 = a0; req_b0 = b0;
    req_sel1 = s1; req_a1 = a1; req_b1 = b1; res_ready = rdy;
    #1;
    exp_rdy = 2'b00;
    gid = 0;
    if (stage == 0 && v != 2'b00) begin
      gid = (v == 2'b11) ? ptr_m : ((v == 2'b10) ? 1 : 0);
      exp_rdy = (gid == 1) ? 2'b10 : 2'b01;
    end
    chk("req_ready", int'(req_ready), int'(exp_rdy));
    chk("req_ready_cnt2", int'(req_ready2), int'(exp_rdy));
    chk("res_valid", int'(res_valid), (stage == 2) ? 1 : 0);
    if (stage == 0 && v != 2'b00) begin
      ai = (gid == 1) ? int'($signed(a1)) : int'($signed(a0));
      bi = (gid == 1) ? int'($signed(b1)) : int'($signed(b0));
      r  = (((gid == 1) ? s1 : s0) == 1'b1) ? ai - bi : ai + bi;
      e.y  = 6'(r);
      e.of = (r > 31 || r < -32);
      e.id = (gid == 1);
      if (e.of && cnt8_m < 255) cnt8_m++;
      if (e.of && cnt2_m < 3) cnt2_m++;
      e.cnt8 = cnt8_m;
      e.cnt2 = cnt2_m;
      sb.push_back(e);
      ptr_m = 1 - gid;
      stage = 1;
    end else if (stage == 1) begin
      stage = 2;
    end else if (stage == 2 && rdy) begin
      stage = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b1);
  endtask

  // Monitor: every presented result must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (res_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sb[0];
          chk("res_y", int'(res_y), int'(e.y));
          chk("res_of", int'(res_of), int'(e.of));
          chk("res_id", int'(res_id), int'(e.id));
          chk("of_cnt", int'(of_cnt), e.cnt8);
          chk("of_cnt_sat2", int'(of_cnt2), e.cnt2);
          chk("res_y_cnt2", int'(res_y2), int'(e.y));
          if (res_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00; req_sel0 = 1'b0; req_sel1 = 1'b0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; res_ready = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs();
    #2 rst_n = 1'b1;

    // Known-answer operations, including wrap and overflow cases.
    cycle(2'b01, 1'b0, 6'd20, 6'd15, 1'b0, 6'd0, 6'd0, 1'b1);
    idle(3);
    cycle(2'b10, 1'b0, 6'd0, 6'd0, 1'b1, 6'(-20), 6'd15, 1'b1);
    idle(3);
    cycle(2'b10, 1'b0, 6'd0, 6'd0, 1'b1, 6'(-5), 6'd7, 1'b1);
    idle(3);

    // Continuous contention: grants must alternate.
    for (int i = 0; i < 16; i++)
      cycle(2'b11, 1'b0, 6'(i), 6'd31, 1'b1, 6'(-i), 6'd31, 1'b1);
    idle(3);

    // Back-pressure: result and data held, no new grant.
    cycle(2'b01, 1'b1, 6'd10, 6'd3, 1'b0, 6'd0, 6'd0, 1'b0);
    cycle(2'b11, 1'b0, 6'd1, 6'd2, 1'b0, 6'd3, 6'd4, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle(2'b11, 1'b0, 6'($urandom), 6'($urandom), 1'b1, 6'($urandom), 6'($urandom), 1'b0);
    cycle(2'b00, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b1);
    idle(3);

    // Four overflowing adds push the narrow counter into saturation.
    for (int i = 0; i < 4; i++) begin
      cycle(2'b01, 1'b0, 6'd31, 6'd31, 1'b0, 6'd0, 6'd0, 1'b1);
      idle(2);
    end

    // Reset while the core is busy: operation must vanish.
    cycle(2'b01, 1'b0, 6'd30, 6'd30, 1'b0, 6'd0, 6'd0, 1'b1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    req_valid = 2'b00;
    @(negedge clk);
    #3 rst_n = 1'b1;
    cycle(2'b10, 1'b0, 6'd0, 6'd0, 1'b0, 6'd5, 6'd9, 1'b1);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cycle(2'($urandom), 1'($urandom), 6'($urandom), 6'($urandom), 1'($urandom),
            6'($urandom), 6'($urandom), ($urandom_range(0, 3) != 0));

    for (int i = 0; i < 20 && (sb.size() != 0 || stage != 0); i++) idle(1);
    chk("drain_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_addsub_arbiter.md
ALU_ADDSUB_ARBITER -- requirements
Module: alu_addsub_arbiter

Interface
REQ-001 Parameter: W, 6, operand/result width (two's complement signed).
REQ-002 Parameter: CNT_W, 8, width of saturating overflow counter.
REQ-003 CLK  input  1  single clock; all state on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 REQ_VALID[1:0]  input  2  requester i presents an operation.
REQ-006 REQ_READY[1:0]  output  2  requester i operation accepted this cycle.
REQ-007 REQ_SEL0, REQ_SEL1  input  1 each  operation select: 0 = A+B, 1 = A-B.
REQ-008 REQ_A0, REQ_B0, REQ_A1, REQ_B1  input  W each  signed operands.
REQ-009 RES_VALID  output  1  result available.
REQ-010 RES_READY  input  1  consumer takes result.
REQ-011 RES_Y  output  W  signed result, wrapped modulo 2^W.
REQ-012 RES_OF  output  1  signed overflow of this result.
REQ-013 RES_ID  output  1  index of requester that issued the result.
REQ-014 OF_CNT  output  CNT_W  total overflowed results since reset, saturating.

Function
REQ-015 FSM states IDLE, EXEC, RESP; shared add/sub core used by at most one operation at a time.
REQ-016 IDLE: if any REQ_VALID, grant one requester, assert REQ_READY for it only (combinational, same cycle), capture SEL/A/B/ID, go to EXEC; else stay.
REQ-017 REQ_READY SHALL be 0 in EXEC and RESP and for the non-granted requester.
REQ-018 Arbitration round-robin: priority pointer PTR (reset 0); both valid -> grant PTR; one valid -> grant it; PTR := granted ID + 1 (mod 2) on each grant.
REQ-019 EXEC: register core Y, OF, ID into result registers, go to RESP (one cycle).
REQ-020 RESP: RES_VALID = 1; RES_Y/RES_OF/RES_ID stable; on RES_READY go to IDLE, else hold.
REQ-021 Latency: grant at edge k -> RES_VALID high after edge k+1; minimum 3 cycles per operation.
REQ-022 Add overflow: A, B same sign and Y sign differs from A; subtract overflow: A, B signs differ and Y sign differs from A.
REQ-023 OF_CNT increments by 1 on the EXEC->RESP edge when OF = 1; holds at 2^CNT_W-1.
REQ-024 Requester changing operands while not granted SHALL have no effect; captured operands immune to later input changes.
REQ-025 RES_VALID low in IDLE and EXEC; RES_Y/RES_OF/RES_ID retain last result outside RESP.

Reset
REQ-026 RST_N low asynchronously forces: state IDLE, PTR 0, RES_VALID 0, RES_Y 0, RES_OF 0, RES_ID 0, OF_CNT 0, REQ_READY 0.
REQ-027 Reset mid-operation (EXEC or RESP) discards the operation; no result delivered after release.
REQ-028 First grant possible in the first cycle with RST_N high.

Structure
REQ-029 Shared package holds state encoding (IDLE/EXEC/RESP) and SEL constants (ADD = 0, SUB = 1).
REQ-030 One sub-module addsub_core_6b: combinational W-bit add/sub producing Y and OF; arbiter instantiates exactly one.

Verification
REQ-031 Req0 SEL=0 A=20 B=15 -> RES_Y=-29, RES_OF=1, RES_ID=0, OF_CNT=1.
REQ-032 Req1 SEL=1 A=-20 B=15 -> RES_Y=29, RES_OF=1; then SEL=1 A=-5 B=7 -> RES_Y=-12, RES_OF=0.
REQ-033 Both valid continuously, RES_READY=1 -> grants alternate 0,1,0,1; RES_ID alternates, no starvation.
REQ-034 RES_READY=0 for 5 cycles in RESP -> RES_VALID and data held, REQ_READY stays 0, no new grant.
REQ-035 RST_N pulsed low during EXEC -> all outputs at reset values immediately; no RES_VALID after release.
REQ-036 CNT_W=2, four overflowing operations -> OF_CNT reads 1,2,3,3.
